// File: rtl/reg_wb_pkg.sv
// Shared definitions for the register write-back arbiter.
// Holds the architectural sizes, the requester ids used by the round-robin
// priority pointer, and the write-request record offered by each producer.
package reg_wb_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned REG_AW   = 5;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_LSU = 1'b1
    } req_id_t;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   set_en, set_addr    destination of an instruction issued this cycle
//   clr_en, clr_addr    register-file write currently on the write port
//   rs1_addr, rs2_addr  source registers being decoded
//   rs1_busy, rs2_busy  source has a write still in flight
//   pending             full pending vector (bit 0 is always 0)
module reg_scoreboard
    import reg_wb_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                set_en,
    input  logic [REG_AW-1:0]   set_addr,
    input  logic                clr_en,
    input  logic [REG_AW-1:0]   clr_addr,
    input  logic [REG_AW-1:0]   rs1_addr,
    input  logic [REG_AW-1:0]   rs2_addr,
    output logic                rs1_busy,
    output logic                rs2_busy,
    output logic [NUM_REGS-1:0] pending
);

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;

    // Set is applied after clear so a same-edge set on the same bit wins.
    always_comb begin
        pending_d = pending_q;
        if (clr_en) begin
            pending_d[clr_addr] = 1'b0;
        end
        if (set_en) begin
            pending_d[set_addr] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending  = pending_q;
    assign rs1_busy = pending_q[rs1_addr];
    assign rs2_busy = pending_q[rs2_addr];

endmodule

// File: rtl/reg_wb_arbiter.sv
// Write-back arbiter in front of the register file's single write port.
// ALU and LSU offer results via valid/ready; one non-x0 write is granted per
// cycle round-robin, x0 writes are accepted and dropped without using the
// port, and the granted write is registered onto wr_*_out.
// Optional scoreboard (macro REG_WB_SCOREBOARD_EN) tracks in-flight
// destinations; without it the issue/rs inputs are ignored and the busy and
// pending outputs are tied to 0.
// Ports:
//   clk_in, rst_in                      clock, synchronous active-high reset
//   alu_valid_in/rd_in/data_in, alu_ready_out   ALU result handshake
//   lsu_valid_in/rd_in/data_in, lsu_ready_out   load result handshake
//   wr_en_out, wr_addr_out, wr_data_out          registered register-file write
//   issue_valid_in, issue_rd_in                  decode issue (scoreboard set)
//   rs1_addr_in, rs2_addr_in, rs1_busy_out, rs2_busy_out, pending_out
module reg_wb_arbiter
    import reg_wb_pkg::*;
(
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                alu_valid_in,
    input  logic [REG_AW-1:0]   alu_rd_in,
    input  logic [XLEN-1:0]     alu_data_in,
    output logic                alu_ready_out,
    input  logic                lsu_valid_in,
    input  logic [REG_AW-1:0]   lsu_rd_in,
    input  logic [XLEN-1:0]     lsu_data_in,
    output logic                lsu_ready_out,
    output logic                wr_en_out,
    output logic [REG_AW-1:0]   wr_addr_out,
    output logic [XLEN-1:0]     wr_data_out,
    input  logic                issue_valid_in,
    input  logic [REG_AW-1:0]   issue_rd_in,
    input  logic [REG_AW-1:0]   rs1_addr_in,
    input  logic [REG_AW-1:0]   rs2_addr_in,
    output logic                rs1_busy_out,
    output logic                rs2_busy_out,
    output logic [NUM_REGS-1:0] pending_out
);

    wb_req_t alu_req;
    wb_req_t lsu_req;
    wb_req_t win_req;
    logic    alu_nz;
    logic    lsu_nz;
    logic    alu_win;
    logic    lsu_win;
    req_id_t ptr_q;
    req_id_t ptr_d;

    assign alu_req = '{valid: alu_valid_in, rd: alu_rd_in, data: alu_data_in};
    assign lsu_req = '{valid: lsu_valid_in, rd: lsu_rd_in, data: lsu_data_in};

    // Only non-x0 requests compete for the port; x0 requests are accepted
    // unconditionally and never touch the pointer.
    always_comb begin
        alu_nz  = alu_req.valid && (alu_req.rd != '0);
        lsu_nz  = lsu_req.valid && (lsu_req.rd != '0);
        alu_win = alu_nz && (!lsu_nz || (ptr_q == REQ_ALU));
        lsu_win = lsu_nz && (!alu_nz || (ptr_q == REQ_LSU));
        win_req = lsu_win ? lsu_req : alu_req;

        ptr_d = ptr_q;
        if (alu_win) begin
            ptr_d = REQ_LSU;
        end else if (lsu_win) begin
            ptr_d = REQ_ALU;
        end

        alu_ready_out = !rst_in && alu_req.valid && ((alu_req.rd == '0) || alu_win);
        lsu_ready_out = !rst_in && lsu_req.valid && ((lsu_req.rd == '0) || lsu_win);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            ptr_q       <= REQ_ALU;
            wr_en_out   <= 1'b0;
            wr_addr_out <= '0;
            wr_data_out <= '0;
        end else begin
            ptr_q     <= ptr_d;
            wr_en_out <= alu_win || lsu_win;
            if (alu_win || lsu_win) begin
                wr_addr_out <= win_req.rd;
                wr_data_out <= win_req.data;
            end
        end
    end

`ifdef REG_WB_SCOREBOARD_EN
    reg_scoreboard u_scoreboard (
        .clk      (clk_in),
        .rst      (rst_in),
        .set_en   (issue_valid_in),
        .set_addr (issue_rd_in),
        .clr_en   (wr_en_out),
        .clr_addr (wr_addr_out),
        .rs1_addr (rs1_addr_in),
        .rs2_addr (rs2_addr_in),
        .rs1_busy (rs1_busy_out),
        .rs2_busy (rs2_busy_out),
        .pending  (pending_out)
    );
`else
    logic unused_sb_inputs;
    assign unused_sb_inputs = ^{issue_valid_in, issue_rd_in, rs1_addr_in, rs2_addr_in};
    assign rs1_busy_out     = 1'b0;
    assign rs2_busy_out     = 1'b0;
    assign pending_out      = '0;
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
module tb_reg_wb_arbiter;
    import reg_wb_pkg::*;

`ifdef REG_WB_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic                clk;
    logic                rst;
    logic                av, lv, iv;
    logic [REG_AW-1:0]   ard, lrd, ird, rs1, rs2;
    logic [XLEN-1:0]     ad, ld;
    logic                a_rdy, l_rdy, we, b1, b2;
    logic [REG_AW-1:0]   wa;
    logic [XLEN-1:0]     wd;
    logic [NUM_REGS-1:0] pend;

    reg_wb_arbiter dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .alu_valid_in   (av),
        .alu_rd_in      (ard),
        .alu_data_in    (ad),
        .alu_ready_out  (a_rdy),
        .lsu_valid_in   (lv),
        .lsu_rd_in      (lrd),
        .lsu_data_in    (ld),
        .lsu_ready_out  (l_rdy),
        .wr_en_out      (we),
        .wr_addr_out    (wa),
        .wr_data_out    (wd),
        .issue_valid_in (iv),
        .issue_rd_in    (ird),
        .rs1_addr_in    (rs1),
        .rs2_addr_in    (rs2),
        .rs1_busy_out   (b1),
        .rs2_busy_out   (b2),
        .pending_out    (pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit        rst;
        bit        av;
        bit [4:0]  ard;
        bit [31:0] ad;
        bit        lv;
        bit [4:0]  lrd;
        bit [31:0] ld;
        bit        iv;
        bit [4:0]  ird;
        bit [4:0]  rs1;
        bit [4:0]  rs2;
        bit        ear;
        bit        elr;
        bit        ewe;
        bit [4:0]  ewa;
        bit [31:0] ewd;
        bit        eb1;
        bit        eb2;
        bit [31:0] epend;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        bit r, bit a_v, bit [4:0] a_rd, bit [31:0] a_d, bit l_v, bit [4:0] l_rd, bit [31:0] l_d,
        bit i_v, bit [4:0] i_rd, bit [4:0] s1, bit [4:0] s2,
        bit e_ar, bit e_lr, bit e_we, bit [4:0] e_wa, bit [31:0] e_wd, bit e_b1, bit e_b2, bit [31:0] e_p);
        vec_t v;
        v.rst = r;  v.av = a_v; v.ard = a_rd; v.ad = a_d; v.lv = l_v; v.lrd = l_rd; v.ld = l_d;
        v.iv = i_v; v.ird = i_rd; v.rs1 = s1; v.rs2 = s2;
        v.ear = e_ar; v.elr = e_lr; v.ewe = e_we; v.ewa = e_wa; v.ewd = e_wd;
        v.eb1 = e_b1; v.eb2 = e_b2; v.epend = e_p;
        return v;
    endfunction

    // Reference model state for the random phase.
    int        m_ptr;
    bit        m_we;
    bit [4:0]  m_wa;
    bit [31:0] m_wd;
    bit [31:0] m_pend;

    initial begin
        rst = 1'b1; av = 0; lv = 0; iv = 0;
        ard = '0; lrd = '0; ird = '0; rs1 = '0; rs2 = '0; ad = '0; ld = '0;

        //          rst av ard ad            lv lrd ld       iv ird rs1 rs2  ar lr we wa wd            b1 b2 pend
        tbl.push_back(mk(1, 1, 5, 32'hDEADBEEF, 0, 0, 0,      0, 0, 0, 0,    0, 0, 0, 0, 0,            0, 0, 0));
        tbl.push_back(mk(0, 1, 5, 32'hDEADBEEF, 0, 0, 0,      0, 0, 0, 0,    1, 0, 0, 0, 0,            0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,            0, 0, 0,      0, 0, 0, 0,    0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,            1, 4, 'h44,   0, 0, 0, 0,    0, 1, 0, 5, 32'hDEADBEEF, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 'h11,         1, 2, 'h22,   0, 0, 0, 0,    1, 0, 1, 4, 'h44,         0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 'h11,         1, 2, 'h22,   0, 0, 0, 0,    0, 1, 1, 1, 'h11,         0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 'h11,         1, 2, 'h22,   0, 0, 0, 0,    1, 0, 1, 2, 'h22,         0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 'h11,         1, 2, 'h22,   0, 0, 0, 0,    0, 1, 1, 1, 'h11,         0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,            0, 0, 0,      0, 0, 0, 0,    0, 0, 1, 2, 'h22,         0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 'h99,         1, 3, 'h33,   0, 0, 0, 0,    1, 1, 0, 2, 'h22,         0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,            0, 0, 0,      0, 0, 0, 0,    0, 0, 1, 3, 'h33,         0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 'h55,         0, 0, 0,      0, 0, 0, 0,    1, 0, 0, 3, 'h33,         0, 0, 0));
        tbl.push_back(mk(0, 1, 6, 'h66,         1, 8, 'h88,   0, 0, 0, 0,    1, 0, 0, 3, 'h33,         0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,            1, 8, 'h88,   0, 0, 0, 0,    0, 1, 1, 6, 'h66,         0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,            0, 0, 0,      0, 0, 0, 0,    0, 0, 1, 8, 'h88,         0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,            0, 0, 0,      1, 7, 7, 0,    0, 0, 0, 8, 'h88,         0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,            0, 0, 0,      0, 0, 7, 0,    0, 0, 0, 8, 'h88,         1, 0, 'h80));
        tbl.push_back(mk(0, 0, 0, 0,            0, 0, 0,      0, 0, 7, 0,    0, 0, 0, 8, 'h88,         1, 0, 'h80));
        tbl.push_back(mk(0, 0, 0, 0,            1, 7, 'h77,   0, 0, 7, 0,    0, 1, 0, 8, 'h88,         1, 0, 'h80));
        tbl.push_back(mk(0, 0, 0, 0,            0, 0, 0,      0, 0, 7, 0,    0, 0, 1, 7, 'h77,         1, 0, 'h80));
        tbl.push_back(mk(0, 0, 0, 0,            0, 0, 0,      0, 0, 7, 0,    0, 0, 0, 7, 'h77,         0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,            0, 0, 0,      1, 9, 0, 9,    0, 0, 0, 7, 'h77,         0, 0, 0));
        tbl.push_back(mk(0, 1, 9, 'h9,          0, 0, 0,      0, 0, 0, 9,    1, 0, 0, 7, 'h77,         0, 1, 'h200));
        tbl.push_back(mk(0, 0, 0, 0,            0, 0, 0,      1, 9, 0, 9,    0, 0, 1, 9, 'h9,          0, 1, 'h200));
        tbl.push_back(mk(0, 0, 0, 0,            0, 0, 0,      1, 0, 0, 9,    0, 0, 0, 9, 'h9,          0, 1, 'h200));
        tbl.push_back(mk(0, 0, 0, 0,            0, 0, 0,      0, 0, 0, 9,    0, 0, 0, 9, 'h9,          0, 1, 'h200));
        tbl.push_back(mk(0, 0, 0, 0,            1, 10, 'hAA,  0, 0, 0, 9,    0, 1, 0, 9, 'h9,          0, 1, 'h200));
        tbl.push_back(mk(0, 1, 13, 'hD3,        0, 0, 0,      0, 0, 0, 9,    1, 0, 1, 10, 'hAA,        0, 1, 'h200));
        tbl.push_back(mk(1, 1, 11, 'hB1,        1, 12, 'hC2,  0, 0, 0, 9,    0, 0, 1, 13, 'hD3,        0, 1, 'h200));
        tbl.push_back(mk(0, 1, 11, 'hB1,        1, 12, 'hC2,  0, 0, 0, 9,    1, 0, 0, 0, 0,            0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,            1, 12, 'hC2,  0, 0, 0, 0,    0, 1, 1, 11, 'hB1,        0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,            0, 0, 0,      0, 0, 0, 0,    0, 0, 1, 12, 'hC2,        0, 0, 0));

        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst; av = tbl[i].av; ard = tbl[i].ard; ad = tbl[i].ad;
            lv = tbl[i].lv; lrd = tbl[i].lrd; ld = tbl[i].ld;
            iv = tbl[i].iv; ird = tbl[i].ird; rs1 = tbl[i].rs1; rs2 = tbl[i].rs2;
            @(negedge clk);
            chk($sformatf("t%0d_alu_ready", i), 32'(a_rdy), 32'(tbl[i].ear));
            chk($sformatf("t%0d_lsu_ready", i), 32'(l_rdy), 32'(tbl[i].elr));
            chk($sformatf("t%0d_wr_en", i),     32'(we),    32'(tbl[i].ewe));
            chk($sformatf("t%0d_wr_addr", i),   32'(wa),    32'(tbl[i].ewa));
            chk($sformatf("t%0d_wr_data", i),   wd,         tbl[i].ewd);
            chk($sformatf("t%0d_rs1_busy", i),  32'(b1),    32'(tbl[i].eb1 & SB));
            chk($sformatf("t%0d_rs2_busy", i),  32'(b2),    32'(tbl[i].eb2 & SB));
            chk($sformatf("t%0d_pending", i),   pend,       SB ? tbl[i].epend : 32'h0);
            @(posedge clk);
            #1;
        end

        // Random phase against a rule-level model.
        av = 0; lv = 0; iv = 0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        m_ptr = 0; m_we = 0; m_wa = '0; m_wd = '0; m_pend = '0;

        for (int unsigned cyc = 0; cyc < 3000; cyc++) begin
            int win;
            bit anz, lnz, e_ar, e_lr;
            bit [31:0] np;

            rst = ($urandom_range(0, 99) == 0);
            if (!av) begin
                av  = ($urandom_range(0, 2) != 0);
                ard = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
                ad  = $urandom;
            end
            if (!lv) begin
                lv  = ($urandom_range(0, 2) != 0);
                lrd = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
                ld  = $urandom;
            end
            ird = 5'($urandom);
            iv  = ($urandom_range(0, 1) == 1) && !m_pend[ird];
            rs1 = 5'($urandom);
            rs2 = ($urandom_range(0, 1) == 1) ? m_wa : 5'($urandom);

            anz = av && (ard != 0);
            lnz = lv && (lrd != 0);
            win = -1;
            if (anz && lnz) win = m_ptr;
            else if (anz)   win = 0;
            else if (lnz)   win = 1;
            e_ar = !rst && av && (ard == 0 || win == 0);
            e_lr = !rst && lv && (lrd == 0 || win == 1);

            @(negedge clk);
            chk("rnd_alu_ready", 32'(a_rdy), 32'(e_ar));
            chk("rnd_lsu_ready", 32'(l_rdy), 32'(e_lr));
            chk("rnd_wr_en",     32'(we),    32'(m_we));
            chk("rnd_wr_addr",   32'(wa),    32'(m_wa));
            chk("rnd_wr_data",   wd,         m_wd);
            chk("rnd_rs1_busy",  32'(b1),    32'(SB & m_pend[rs1]));
            chk("rnd_rs2_busy",  32'(b2),    32'(SB & m_pend[rs2]));
            chk("rnd_pending",   pend,       SB ? m_pend : 32'h0);

            if (rst) begin
                m_ptr = 0; m_we = 0; m_wa = '0; m_wd = '0; m_pend = '0;
            end else begin
                np = m_pend;
                if (m_we) np[m_wa] = 1'b0;
                if (iv && ird != 0) np[ird] = 1'b1;
                m_pend = np;
                if (win >= 0) begin
                    m_we  = 1;
                    m_wa  = (win == 0) ? ard : lrd;
                    m_wd  = (win == 0) ? ad : ld;
                    m_ptr = 1 - win;
                end else begin
                    m_we = 0;
                end
            end

            @(posedge clk);
            #1;
            if (e_ar) av = 0;
            if (e_lr) lv = 0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_wb_arbiter.md
# reg_wb_arbiter

Write-back arbiter and scoreboard in front of the 32-entry register file's single write port. Two producers, the ALU and the load/store unit, compete for the port. Each offers a result with a valid/ready handshake. The block grants one write per cycle round-robin, drops writes to x0 without using the port, and drives a registered write to the register file. An optional scoreboard tracks destination registers with results still in flight, so decode can stall on read-after-write hazards.

## Interface
- XLEN, 32, data width
- NUM_REGS, 32, architectural register count
- REG_AW, 5, register address width
- clk_in  in  1  clock
- rst_in  in  1  reset, synchronous, active-high
- alu_valid_in  in  1  ALU result offered
- alu_rd_in  in  REG_AW  ALU destination register
- alu_data_in  in  XLEN  ALU result
- alu_ready_out  out  1  ALU result accepted this cycle
- lsu_valid_in  in  1  load result offered
- lsu_rd_in  in  REG_AW  load destination register
- lsu_data_in  in  XLEN  load data
- lsu_ready_out  out  1  load result accepted this cycle
- wr_en_out  out  1  register-file write enable
- wr_addr_out  out  REG_AW  register-file write address
- wr_data_out  out  XLEN  register-file write data
- issue_valid_in  in  1  decode issues an instruction that writes issue_rd_in
- issue_rd_in  in  REG_AW  destination of the issued instruction
- rs1_addr_in, rs2_addr_in  in  REG_AW  source registers being decoded
- rs1_busy_out, rs2_busy_out  out  1  source register has a pending write
- pending_out  out  NUM_REGS  scoreboard bit vector

## Operation
- **Transfer rule.** A result transfers when valid and ready are both high. A producer holds valid, rd and data stable until it is accepted. The ready outputs are combinational from the valids, the rd fields and the priority pointer. Both ready outputs are 0 while rst_in is high.
- **x0 requests.** A request with rd == 0 is accepted at once (ready = 1). It issues no write and does not change the priority pointer. If one requester targets x0 and the other targets a non-zero register, both are accepted in the same cycle.
- **Single non-x0 request.** It is granted immediately.
- **Two non-x0 requests.** The priority pointer decides: 0 selects ALU, 1 selects LSU. The pointer resets to 0.
- **Pointer update.** After any granted non-x0 write, the pointer moves to the other requester. A continuously valid requester therefore waits at most 1 cycle.
- **Same rd from both.** If both requesters target the same rd in the same cycle, they are written in grant order. Ordering between producers is the issue logic's responsibility.
- **Write output.** wr_en/addr/data_out are registered from the granted request.
- **Idle cycles.** wr_en_out = 0 whenever no non-x0 request was granted. wr_addr_out and wr_data_out hold their last values.
- **Scoreboard set.** On issue_valid_in with issue_rd_in != 0, pending[issue_rd_in] is set at the clock edge.
- **Scoreboard clear.** pending[wr_addr_out] is cleared at the clock edge that ends a cycle with wr_en_out = 1.
- **Set and clear on the same bit in the same edge.** Set wins.
- **x0 bit.** pending[0] is always 0.
- **Busy outputs.** rsN_busy_out = pending[rsN_addr_in], combinational. It is always 0 for x0.
- **WAW restriction.** Decode must not issue to a register whose pending bit is set. The block keeps a single bit per register, not a count.

## Timing
- Reset values: wr_en_out 0, wr_addr_out 0, wr_data_out 0, pointer 0, pending_out all 0, ready outputs 0.
- Acceptance cycle N: the write appears on wr_*_out in cycle N+1. The register file commits it at the end of N+1.
- Issue in cycle N: the pending bit is visible on busy outputs in cycle N+1.
- Pending bit lifetime: set through the cycle in which wr_en_out is high for that register. It reads 0 from the following cycle.
- Reset asserted mid-operation: at the next edge any in-flight granted write is discarded (wr_en_out = 0), the pointer returns to 0 and the scoreboard is cleared. Producers must re-offer their results after reset.
- Throughput: one register write per cycle, plus any number of x0 drops in the same cycle.

## Configuration
- REG_WB_SCOREBOARD_EN defined: the scoreboard is built as described above.
- REG_WB_SCOREBOARD_EN undefined:
  - issue_valid_in, issue_rd_in, rs1_addr_in and rs2_addr_in are ignored.
  - rs1_busy_out, rs2_busy_out and pending_out are tied to 0.
  - Arbitration and write behaviour are unchanged.
  - Ports remain present in both builds.

## Structure
- Shared package reg_wb_pkg holds:
  - XLEN, NUM_REGS and REG_AW constants;
  - requester ids REQ_ALU = 0 and REQ_LSU = 1;
  - the write-request struct {valid, rd, data}.
- One sub-module, reg_scoreboard, contains the pending vector, set/clear logic and the two busy lookups. It is instantiated only under REG_WB_SCOREBOARD_EN.

## Test plan
- After reset, ALU only: alu rd = 5, data = 0xDEADBEEF. Expect alu_ready_out = 1 in cycle 0, and wr_en_out = 1, wr_addr_out = 5, wr_data_out = 0xDEADBEEF in cycle 1. The pointer moves to LSU.
- Both valid for 4 cycles: alu rd = 1, lsu rd = 2, both held valid after acceptance. Expect grants ALU, LSU, ALU, LSU, and writes to 1, 2, 1, 2 one cycle later.
- ALU rd = 0 with LSU rd = 3: both ready in the same cycle. Exactly one write to register 3, and the pointer does not change because of the x0 drop.
- Issue to rd = 7, then the LSU returns rd = 7 three cycles later:
  - rs1_addr_in = 7 gives rs1_busy_out = 1 from the issue+1 cycle through the cycle wr_en_out = 1;
  - rs1_busy_out = 0 the cycle after.
- Same-edge set and clear on register 9: issue_valid_in = 1 with issue_rd_in = 9 while wr_en_out = 1 and wr_addr_out = 9. pending[9] stays 1.
- rst_in asserted while an LSU write is granted: wr_en_out = 0 next cycle, pending_out = 0, and the next contested grant goes to ALU.
